// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA timing generator. An integer clock-enable divider derives
//   the pixel rate from clk; horizontal/vertical counters walk the frame in the
//   order active, front porch, sync, back porch. All video outputs are
//   registered one clk after the counter value they describe, so they stay
//   aligned to the same pixel.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   px_en        out  pixel-clock enable, one clk wide every CLK_DIV clks
//   hsync        out  horizontal sync, asserted level H_POL
//   vsync        out  vertical sync, asserted level V_POL
//   activevideo  out  high while (x_px, y_px) lies in the visible area
//   x_px, y_px   out  registered horizontal/vertical counters (CNT_W bits)
//   line_start   out  one-clk strobe when outputs show hc==0
//   frame_start  out  one-clk strobe when outputs show hc==0, vc==0
//   frame_cnt    out  completed-frame counter (FRAME_W bits)
//
// Build option
//   VGA_FRAME_CNT_EN : when defined, frame_cnt counts every frame_start except
//                      the first after reset; otherwise it is tied to zero.

module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 24,
   parameter int unsigned H_SYNC   = 40,
   parameter int unsigned H_BP     = 128,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 9,
   parameter int unsigned V_SYNC   = 3,
   parameter int unsigned V_BP     = 28,
   parameter logic        H_POL    = 1'b0,
   parameter logic        V_POL    = 1'b0,
   parameter int unsigned CLK_DIV  = 1,
   parameter int unsigned CNT_W    = 10,
   parameter int unsigned FRAME_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   output logic               px_en,
   output logic               hsync,
   output logic               vsync,
   output logic               activevideo,
   output logic [CNT_W-1:0]   x_px,
   output logic [CNT_W-1:0]   y_px,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END  = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END  = VS_BEG + V_SYNC;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DIV_W-1:0] div;
   logic [CNT_W-1:0] hc;
   logic [CNT_W-1:0] vc;
   logic             h_last;
   logic             v_last;
   logic             h_in_sync;
   logic             v_in_sync;
   logic             h_vis;
   logic             v_vis;

   // Comparisons are done at 32 bits so boundaries equal to 2^CNT_W do not
   // truncate to zero.
   assign h_last    = (32'(hc) == H_TOTAL - 1);
   assign v_last    = (32'(vc) == V_TOTAL - 1);
   assign h_in_sync = (32'(hc) >= HS_BEG) && (32'(hc) < HS_END);
   assign v_in_sync = (32'(vc) >= VS_BEG) && (32'(vc) < VS_END);
   assign h_vis     = (32'(hc) < H_ACTIVE);
   assign v_vis     = (32'(vc) < V_ACTIVE);

   always_ff @(posedge clk) begin
      if (reset) begin
         div         <= '0;
         px_en       <= 1'b0;
         hc          <= '0;
         vc          <= '0;
         hsync       <= ~H_POL;
         vsync       <= ~V_POL;
         activevideo <= 1'b0;
         x_px        <= '0;
         y_px        <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div         <= (32'(div) == CLK_DIV - 1) ? '0 : div + 1'b1;
         // px_en is registered, so it trails div==0 by one clk; the counters
         // advance on the clk where the registered enable is high.
         px_en       <= (div == '0);
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (px_en) begin
            hsync       <= h_in_sync ? H_POL : ~H_POL;
            vsync       <= v_in_sync ? V_POL : ~V_POL;
            activevideo <= h_vis && v_vis;
            x_px        <= hc;
            y_px        <= vc;
            line_start  <= (hc == '0);
            frame_start <= (hc == '0) && (vc == '0);
            if (h_last) begin
               hc <= '0;
               vc <= v_last ? '0 : vc + 1'b1;
            end else begin
               hc <= hc + 1'b1;
            end
         end
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [FRAME_W-1:0] frame_cnt_q;
   logic               first_seen;

   // Increments alongside the frame_start strobe; the first frame after reset
   // only arms the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
         first_seen  <= 1'b0;
      end else if (px_en && (hc == '0) && (vc == '0)) begin
         if (first_seen) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
         first_seen <= 1'b1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a small 8x6 frame (H=4/1/2/1, V=3/1/1/1).
// Three instances: a (CLK_DIV=1, active-low syncs), b (CLK_DIV=3), c (active-
// high syncs). Expected outputs come from a closed-form model indexed by the
// number of clk edges since reset release.

module tb_vga_timing_gen;

   typedef struct packed {
      logic       pe;
      logic       hs;
      logic       vs;
      logic       av;
      logic [3:0] x;
      logic [3:0] y;
      logic       ls;
      logic       fs;
      logic [1:0] fc;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

   logic       pe_a, hs_a, vs_a, av_a, ls_a, fs_a;
   logic [3:0] x_a, y_a;
   logic [1:0] fc_a;
   logic       pe_b, hs_b, vs_b, av_b, ls_b, fs_b;
   logic [3:0] x_b, y_b;
   logic [1:0] fc_b;
   logic       pe_c, hs_c, vs_c, av_c, ls_c, fs_c;
   logic [3:0] x_c, y_c;
   logic [1:0] fc_c;

   obs_t obs_a, obs_b, obs_c;
   assign obs_a = {pe_a, hs_a, vs_a, av_a, x_a, y_a, ls_a, fs_a, fc_a};
   assign obs_b = {pe_b, hs_b, vs_b, av_b, x_b, y_b, ls_b, fs_b, fc_b};
   assign obs_c = {pe_c, hs_c, vs_c, av_c, x_c, y_c, ls_c, fs_c, fc_c};

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(1), .CNT_W(4), .FRAME_W(2)
   ) dut_a (
      .clk(clk), .reset(rst_a), .px_en(pe_a), .hsync(hs_a), .vsync(vs_a),
      .activevideo(av_a), .x_px(x_a), .y_px(y_a), .line_start(ls_a),
      .frame_start(fs_a), .frame_cnt(fc_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(3), .CNT_W(4), .FRAME_W(2)
   ) dut_b (
      .clk(clk), .reset(rst_b), .px_en(pe_b), .hsync(hs_b), .vsync(vs_b),
      .activevideo(av_b), .x_px(x_b), .y_px(y_b), .line_start(ls_b),
      .frame_start(fs_b), .frame_cnt(fc_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .CNT_W(4), .FRAME_W(2)
   ) dut_c (
      .clk(clk), .reset(rst_c), .px_en(pe_c), .hsync(hs_c), .vsync(vs_c),
      .activevideo(av_c), .x_px(x_c), .y_px(y_c), .line_start(ls_c),
      .frame_start(fs_c), .frame_cnt(fc_c)
   );

   int errors = 0;
   int checks = 0;

   // Edges since reset release per instance (0 = reset state shown).
   int ka = 0, kb = 0, kc = 0;
   bit watch_a = 0, watch_b = 0, watch_c = 0;
   obs_t qa[$], qb[$], qc[$];

   // k: clk edges since release. px_en shows high after edges 1, 1+div, ...;
   // pixel p is decoded on edge 2 + p*div and shown from then on.
   function automatic obs_t model(int k, int div, bit hpol, bit vpol);
      obs_t e;
      int m, p, ph, hc, vc;
      e.pe = 1'b0; e.hs = ~hpol; e.vs = ~vpol; e.av = 1'b0;
      e.x = 4'd0; e.y = 4'd0; e.ls = 1'b0; e.fs = 1'b0; e.fc = 2'd0;
      if (k >= 1) e.pe = (((k - 1) % div) == 0);
      if (k >= 2) begin
         m  = k - 2;
         p  = m / div;
         ph = m % div;
         hc = p % 8;
         vc = (p / 8) % 6;
         e.hs = (hc == 5 || hc == 6) ? hpol : ~hpol;
         e.vs = (vc == 4) ? vpol : ~vpol;
         e.av = (hc < 4) && (vc < 3);
         e.x  = 4'(hc);
         e.y  = 4'(vc);
         e.ls = (ph == 0) && (hc == 0);
         e.fs = e.ls && (vc == 0);
`ifdef VGA_FRAME_CNT_EN
         e.fc = 2'((p / 48) % 4);
`endif
      end
      return e;
   endfunction

   // Pushes the expected post-edge outputs for watched instances, then
   // advances one edge and samples 1 time unit later.
   task automatic tick();
      if (watch_a) qa.push_back(model(rst_a ? 0 : ka + 1, 1, 1'b0, 1'b0));
      if (watch_b) qb.push_back(model(rst_b ? 0 : kb + 1, 3, 1'b0, 1'b0));
      if (watch_c) qc.push_back(model(rst_c ? 0 : kc + 1, 1, 1'b1, 1'b1));
      @(posedge clk);
      #1;
      ka = rst_a ? 0 : ka + 1;
      kb = rst_b ? 0 : kb + 1;
      kc = rst_c ? 0 : kc + 1;
   endtask

   task automatic test_reset();
      obs_t e;
      watch_a = 1; watch_b = 1; watch_c = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         e = qa.pop_front(); checks++;
         if (obs_a !== e) begin
            errors++; $display("FAIL reset_a got=%h exp=%h", obs_a, e);
         end
         e = qb.pop_front(); checks++;
         if (obs_b !== e) begin
            errors++; $display("FAIL reset_b got=%h exp=%h", obs_b, e);
         end
         e = qc.pop_front(); checks++;
         if (obs_c !== e) begin
            errors++; $display("FAIL reset_c got=%h exp=%h", obs_c, e);
         end
      end
      checks++;
      if ({hs_c, vs_c} !== 2'b00) begin
         errors++; $display("FAIL reset_pol_high got=%b exp=00", {hs_c, vs_c});
      end
      watch_b = 0; watch_c = 0;
   endtask

   task automatic test_small_frame();
      obs_t e;
      int active_cnt = 0;
      int fs_n = 0;
      int last_fs = -1, last_ls = -1;
      logic [1:0] fc_seen [5];
      rst_a = 1'b0;
      for (int j = 1; j <= 240; j++) begin
         tick();
         e = qa.pop_front(); checks++;
         if (obs_a !== e) begin
            errors++; $display("FAIL frame_a k=%0d got=%h exp=%h", ka, obs_a, e);
         end
         if (j >= 2 && j <= 49 && av_a === 1'b1) active_cnt++;
         if (ls_a === 1'b1) begin
            if (last_ls >= 0) begin
               checks++;
               if (j - last_ls !== 8) begin
                  errors++; $display("FAIL line_period got=%0d exp=8", j - last_ls);
               end
            end
            last_ls = j;
         end
         if (fs_a === 1'b1) begin
            if (last_fs >= 0) begin
               checks++;
               if (j - last_fs !== 48) begin
                  errors++; $display("FAIL frame_period got=%0d exp=48", j - last_fs);
               end
            end
            if (fs_n < 5) fc_seen[fs_n] = fc_a;
            fs_n++;
            last_fs = j;
         end
      end
      checks++;
      if (active_cnt !== 12) begin
         errors++; $display("FAIL active_count got=%0d exp=12", active_cnt);
      end
      checks++;
      if (fs_n !== 5) begin
         errors++; $display("FAIL frame_start_count got=%0d exp=5", fs_n);
      end
      for (int n = 0; n < 5; n++) begin
         logic [1:0] want;
`ifdef VGA_FRAME_CNT_EN
         want = 2'(n % 4);
`else
         want = 2'd0;
`endif
         checks++;
         if (fc_seen[n] !== want) begin
            errors++; $display("FAIL frame_cnt[%0d] got=%0d exp=%0d", n, fc_seen[n], want);
         end
      end
   endtask

   task automatic test_mid_reset();
      obs_t e;
      bit found = 0;
      for (int j = 0; j < 100 && !found; j++) begin
         tick();
         e = qa.pop_front(); checks++;
         if (obs_a !== e) begin
            errors++; $display("FAIL seek_a k=%0d got=%h exp=%h", ka, obs_a, e);
         end
         if (x_a === 4'd6 && y_a === 4'd2) found = 1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL seek_x6_y2 got=timeout exp=found");
      end
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      e = qa.pop_front(); checks++;
      if (obs_a !== e) begin
         errors++; $display("FAIL midreset_vals got=%h exp=%h", obs_a, e);
      end
      for (int j = 0; j < 2; j++) begin
         tick();
         e = qa.pop_front(); checks++;
         if (obs_a !== e) begin
            errors++; $display("FAIL midreset_restart k=%0d got=%h exp=%h", ka, obs_a, e);
         end
      end
      checks++;
      if ({fs_a, x_a, y_a} !== 9'b1_0000_0000) begin
         errors++; $display("FAIL midreset_frame_start got=%b exp=100000000", {fs_a, x_a, y_a});
      end
      watch_a = 0;
   endtask

   task automatic test_clk_div();
      obs_t e;
      int last_pe = -1, last_fs = -1;
      logic prev_ls = 1'b0;
      watch_b = 1;
      rst_b = 1'b0;
      for (int j = 1; j <= 2 * 144 + 6; j++) begin
         tick();
         e = qb.pop_front(); checks++;
         if (obs_b !== e) begin
            errors++; $display("FAIL div3_b k=%0d got=%h exp=%h", kb, obs_b, e);
         end
         if (pe_b === 1'b1) begin
            if (last_pe >= 0) begin
               checks++;
               if (j - last_pe !== 3) begin
                  errors++; $display("FAIL px_en_period got=%0d exp=3", j - last_pe);
               end
            end
            last_pe = j;
         end
         if (fs_b === 1'b1) begin
            if (last_fs >= 0) begin
               checks++;
               if (j - last_fs !== 144) begin
                  errors++; $display("FAIL div3_frame_period got=%0d exp=144", j - last_fs);
               end
            end
            last_fs = j;
         end
         if (prev_ls === 1'b1) begin
            checks++;
            if (ls_b !== 1'b0) begin
               errors++; $display("FAIL strobe_width got=%b exp=0", ls_b);
            end
         end
         prev_ls = ls_b;
      end
      watch_b = 0;
   endtask

   task automatic test_polarity();
      obs_t e;
      watch_c = 1;
      rst_c = 1'b0;
      for (int j = 1; j <= 60; j++) begin
         tick();
         e = qc.pop_front(); checks++;
         if (obs_c !== e) begin
            errors++; $display("FAIL pol_c k=%0d got=%h exp=%h", kc, obs_c, e);
         end
         if (j >= 2) begin
            int hc;
            hc = (j - 2) % 8;
            checks++;
            if (hs_c !== ((hc == 5) || (hc == 6))) begin
               errors++; $display("FAIL hsync_high hc=%0d got=%b", hc, hs_c);
            end
         end
      end
      watch_c = 0;
   endtask

   initial begin
      test_reset();
      test_small_frame();
      test_mid_reset();
      test_clk_div();
      test_polarity();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Parametrised VGA timing generator; successor to the fixed 640x480@72 sync generator.
- Produces hsync, vsync, activevideo, pixel coordinates and line/frame start strobes from programmable porch, sync and active lengths.
- Configurable sync polarity.
- Pixel rate derived from the system clock by an integer clock-enable divider; no PLL or clock muxing inside the block.
- Sits between the clock/reset block and the pixel renderers; all downstream logic runs on `clk` qualified by `px_en`.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 24: horizontal front porch
- `H_SYNC`, 40: hsync pulse length
- `H_BP`, 128: horizontal back porch
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 9: vertical front porch
- `V_SYNC`, 3: vsync pulse length
- `V_BP`, 28: vertical back porch
- `H_POL`, 0: hsync asserted level (0 = active-low)
- `V_POL`, 0: vsync asserted level
- `CLK_DIV`, 1: clk cycles per pixel, ≥1
- `CNT_W`, 10: counter and coordinate width; H_TOTAL and V_TOTAL must each be ≤ 2^CNT_W
- `FRAME_W`, 8: frame counter width
---
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `px_en` out 1: pixel-clock enable, one clk wide
- `hsync` out 1: horizontal sync, level per H_POL
- `vsync` out 1: vertical sync, level per V_POL
- `activevideo` out 1: high while (x_px, y_px) is visible
- `x_px` out CNT_W: horizontal counter, registered
- `y_px` out CNT_W: vertical counter, registered
- `line_start` out 1: one-clk strobe when outputs show hc==0
- `frame_start` out 1: one-clk strobe when outputs show hc==0, vc==0
- `frame_cnt` out FRAME_W: completed-frame counter (see Configuration)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active [0, H_ACTIVE), then front porch, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then back porch. Vertical order is the same.
- Divider `div` counts 0..CLK_DIV-1 and wraps. `px_en` = (div==0); with CLK_DIV=1, px_en is constantly 1 outside reset.
- On each px_en cycle:
  - Outputs register the decode of the current (hc, vc).
  - hc advances. hc==H_TOTAL-1 wraps to 0 and advances vc.
  - vc==V_TOTAL-1 with hc wrap → both counters go to 0.
- Decode: `activevideo` = hc<H_ACTIVE && vc<V_ACTIVE. `hsync` = H_POL inside the hsync window, else ~H_POL; `vsync` likewise. `x_px`=hc, `y_px`=vc across the whole frame; consumers qualify with activevideo.
- Between px_en cycles, hsync/vsync/activevideo/x_px/y_px hold their values. `line_start`/`frame_start` are high only on the clk right after the px_en that decoded hc==0.
- All arithmetic is unsigned CNT_W; counters never exceed TOTAL-1.

## Timing
- Reset values (held while `reset`=1):
  - div=hc=vc=0, px_en=0
  - hsync=~H_POL, vsync=~V_POL
  - activevideo=0, x_px=y_px=0
  - line_start=frame_start=0, frame_cnt=0
- First clk after reset release: px_en=1. Next clk: outputs show (0,0), activevideo=1, line_start=frame_start=1.
- Latency: one clk from the counter value to all outputs; every output is aligned to the same pixel.
- Reset asserted mid-frame: takes effect on the next edge. There is no partial line; restart is exactly as from power-up.

## Configuration
- `VGA_FRAME_CNT_EN` defined: `frame_cnt` increments on every frame_start except the first after reset, wrapping modulo 2^FRAME_W.
- Not defined: `frame_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Small config H=4/1/2/1 (total 8), V=3/1/1/1 (total 6), CLK_DIV=1, pols 0:
  - hsync=0 exactly when x_px ∈ {5,6}.
  - vsync=0 exactly on y_px=4.
  - activevideo=1 for x<4 && y<3; 12 active pixels per frame.
- Same config: frame_start period = 48 clks; line_start period = 8 clks; y_px wraps 5→0 with x_px 7→0.
- CLK_DIV=3: px_en period = 3 clks. Outputs are stable across the 2 non-enable clks. Strobes are 1 clk wide. Frame period = 144 clks.
- H_POL=1, V_POL=1:
  - During reset, hsync=vsync=0.
  - hsync=1 for x ∈ {5,6}.
- Assert reset at x=6, y=2 for 1 clk → reset values next clk. Then px_en, then (0,0) with frame_start=1.
- With VGA_FRAME_CNT_EN and FRAME_W=2, run 5 frames → frame_cnt sequence 0,1,2,3,0. Without the macro, frame_cnt stays 0.
